// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the branch prediction controller.
//   OP_BRANCH / OP_JAL : RV32 opcodes recognised by the fetch predictor
//   ctr_e              : 2-bit saturating counter encoding
//   slot_t             : in-flight prediction record tracked through D and E
//   ctr_update         : saturating counter step
package bp_pkg;

    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic        valid;
        logic        pred_taken;
        logic [31:0] pred_target;
    } slot_t;

    function automatic ctr_e ctr_update(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        if (taken && (cur != ST)) begin
            nxt = ctr_e'(cur + 2'd1);
        end else if (!taken && (cur != SNT)) begin
            nxt = ctr_e'(cur - 2'd1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_bht.sv
// bp_bht: branch history table of 2-bit saturating counters.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (all entries -> WNT)
//   ridx_i        : combinational read index
//   rdata_o       : counter at ridx_i (pre-write value on a same-cycle collision)
//   we_i          : apply a saturating update at the next rising edge
//   widx_i        : write index
//   taken_i       : update direction (1 = increment, 0 = decrement)
module bp_bht
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [IDX_BITS-1:0] ridx_i,
    output ctr_e                rdata_o,
    input  logic                we_i,
    input  logic [IDX_BITS-1:0] widx_i,
    input  logic                taken_i
);

    localparam int unsigned Entries = 2 ** IDX_BITS;

    ctr_e cnt_q [Entries];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < Entries; i++) begin
                cnt_q[i] <= WNT;
            end
        end else if (we_i) begin
            cnt_q[widx_i] <= ctr_update(cnt_q[widx_i], taken_i);
        end
    end

    // Read straight from the array so a colliding write is only seen next cycle.
    assign rdata_o = cnt_q[ridx_i];

endmodule

// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: fetch-stage next-PC predictor and E-stage redirect controller.
// Predicts conditional branches from the BHT and JAL as always taken, tracks each
// prediction through D and E, and on a mispredict redirects fetch and flushes F/D, D/E.
// Ports:
//   iClk, iRstN            : clock, async active-low reset
//   iPCF, iInstructionF    : fetch PC and instruction
//   iStallF                : F and D hold; E receives a bubble
//   iBubbleE               : hazard unit bubble into E
//   iPCE, iBranchE, iJumpE : E-stage instruction PC and kind
//   iTakenE, iTargetE      : E-stage resolved outcome
//   oPCNextF, oPredTakenF  : next fetch PC, F-stage prediction
//   oFlushFD               : mispredict flush
//   oBranchCnt, oMispredCnt: perf counters, present only with BP_PERF_CNT_EN defined
module branch_predict_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6
) (
    input  logic        iClk,
    input  logic        iRstN,
    input  logic [31:0] iPCF,
    input  logic [31:0] iInstructionF,
    input  logic        iStallF,
    input  logic        iBubbleE,
    input  logic [31:0] iPCE,
    input  logic        iBranchE,
    input  logic        iJumpE,
    input  logic        iTakenE,
    input  logic [31:0] iTargetE,
    output logic [31:0] oPCNextF,
    output logic        oPredTakenF,
    output logic        oFlushFD,
    output logic [31:0] oBranchCnt,
    output logic [31:0] oMispredCnt
);

    logic [6:0]          opcode_f;
    logic [31:0]         b_imm_f;
    logic [31:0]         j_imm_f;
    logic [31:0]         pc_plus4_f;
    logic [31:0]         next_pc_f;
    logic [IDX_BITS-1:0] ridx_f;
    logic [IDX_BITS-1:0] widx_e;
    ctr_e                ctr_f;
    logic                pred_taken_f;
    logic [31:0]         pred_target_f;
    slot_t               d_q, d_d, e_q, e_d;
    logic                actual_taken_e;
    logic                mispred_e;
    logic                bht_we_e;

    // ---------------- Fetch prediction ----------------
    assign opcode_f   = iInstructionF[6:0];
    assign b_imm_f    = {{20{iInstructionF[31]}}, iInstructionF[7], iInstructionF[30:25],
                         iInstructionF[11:8], 1'b0};
    assign j_imm_f    = {{12{iInstructionF[31]}}, iInstructionF[19:12], iInstructionF[20],
                         iInstructionF[30:21], 1'b0};
    assign pc_plus4_f = iPCF + 32'd4;
    assign ridx_f     = iPCF[IDX_BITS+1:2];
    assign widx_e     = iPCE[IDX_BITS+1:2];

    always_comb begin
        pred_taken_f  = 1'b0;
        pred_target_f = pc_plus4_f;
        case (opcode_f)
            OP_BRANCH: begin
                pred_taken_f  = ctr_f[1];
                pred_target_f = iPCF + b_imm_f;
            end
            OP_JAL: begin
                pred_taken_f  = 1'b1;
                pred_target_f = iPCF + j_imm_f;
            end
            default: ;
        endcase
    end

    assign next_pc_f   = pred_taken_f ? pred_target_f : pc_plus4_f;
    assign oPredTakenF = pred_taken_f;

    // ---------------- E-stage resolution and redirect ----------------
    // JALR is never predicted taken, so it always lands here as a mispredict.
    assign actual_taken_e = (iBranchE & iTakenE) | iJumpE;
    assign mispred_e      = e_q.valid &
                            ((actual_taken_e != e_q.pred_taken) |
                             (actual_taken_e & (e_q.pred_target != iTargetE)));
    assign bht_we_e       = e_q.valid & iBranchE;

    assign oFlushFD = mispred_e;
    assign oPCNextF = mispred_e ? (actual_taken_e ? iTargetE : iPCE + 32'd4) : next_pc_f;

    // ---------------- Tracking slots ----------------
    always_comb begin
        d_d = d_q;
        e_d = '0;
        if (mispred_e) begin
            d_d = '0;
        end else if (!iStallF) begin
            e_d = iBubbleE ? '0 : d_q;
            d_d = slot_t'{valid: 1'b1, pred_taken: pred_taken_f, pred_target: pred_target_f};
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            d_q <= '0;
            e_q <= '0;
        end else begin
            d_q <= d_d;
            e_q <= e_d;
        end
    end

    bp_bht #(
        .IDX_BITS(IDX_BITS)
    ) u_bht (
        .clk_i  (iClk),
        .rst_ni (iRstN),
        .ridx_i (ridx_f),
        .rdata_o(ctr_f),
        .we_i   (bht_we_e),
        .widx_i (widx_e),
        .taken_i(iTakenE)
    );

    // ---------------- Performance counters ----------------
`ifdef BP_PERF_CNT_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (e_q.valid && (iBranchE || iJumpE)) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispred_e) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign oBranchCnt  = branch_cnt_q;
    assign oMispredCnt = mispred_cnt_q;
`else
    assign oBranchCnt  = 32'd0;
    assign oMispredCnt = 32'd0;
`endif

endmodule

// File: doc/branch_predict_ctrl.md
# branch_predict_ctrl

- Fetch-stage branch prediction and redirect controller for the 5-stage pipeline.
- Each cycle it predicts the next fetch PC, using a 2-bit-counter branch history table (BHT) for conditional branches and always-taken for JAL.
- It tracks each prediction through D and E and compares it with the outcome resolved in E.
- On a mispredict it redirects fetch, flushes F/D and D/E, and updates the BHT.

## Interface
Parameters:
- IDX_BITS, 6, BHT index width; the BHT has 2^IDX_BITS entries indexed by PC[IDX_BITS+1:2].

Ports:
- iClk  in  1  clock, rising edge.
- iRstN  in  1  reset, asynchronous, active-low.
- iPCF  in  32  fetch PC.
- iInstructionF  in  32  fetched instruction.
- iStallF  in  1  hazard stall: F and D hold.
- iBubbleE  in  1  hazard unit inserts a bubble into E this cycle.
- iPCE  in  32  PC of the instruction in E.
- iBranchE  in  1  instruction in E is a conditional branch.
- iJumpE  in  1  instruction in E is JAL or JALR.
- iTakenE  in  1  branch condition resolved true in E.
- iTargetE  in  32  resolved target in E.
- oPCNextF  out  32  next fetch PC.
- oPredTakenF  out  1  fetch-stage prediction is taken.
- oFlushFD  out  1  flush the F/D and D/E pipeline registers.
- oBranchCnt  out  32  count of resolved branches and jumps (see Configuration).
- oMispredCnt  out  32  count of mispredicts (see Configuration).

## Operation
Fetch prediction (combinational):
- Opcode 7'd99: predict taken iff BHT[idx][1]=1. Target = iPCF + sign-extended B-immediate.
- Opcode 7'd111: always taken. Target = iPCF + sign-extended J-immediate.
- All other opcodes: not taken, next PC = iPCF+4.

Tracking slots:
- Two slots, D and E. Each holds {valid, predTaken, predTarget[31:0]}.
- When iStallF=0: E <= D, unless iBubbleE=1, in which case E <= invalid. D <= {1, F prediction}.
- When iStallF=1: D holds. E <= invalid.

Resolution (E slot valid):
- actualTaken = (iBranchE & iTakenE) | iJumpE.
- mispredict = (actualTaken != predTaken) | (actualTaken & predTarget != iTargetE).
- JALR is never predicted taken, so it always mispredicts when it reaches E.

Redirect:
- On mispredict: oFlushFD=1 and oPCNextF = actualTaken ? iTargetE : iPCE+4.
- The E redirect has priority over the F prediction and over iStallF.
- At the next edge both slots become invalid.

BHT update:
- Applies when the E slot is valid and iBranchE=1, whether or not the branch mispredicted.
- Saturating counter: taken increments (max 11), not-taken decrements (min 00).

Read/write collision:
- If an E update and an F read hit the same index in one cycle, the read returns the old value.
- The write takes effect at the edge.

## Timing
Reset values:
- Both slots invalid.
- All BHT entries 2'b01 (weakly not taken).
- Perf counters 0.
- With slots invalid, oFlushFD=0 and oPCNextF follows the F prediction.

Latencies:
- Prediction latency is 0 cycles (combinational from iPCF/iInstructionF).
- Mispredict is detected combinationally in E; the penalty is 2 fetch cycles.

Other rules:
- Reset asserted mid-operation clears state immediately (async). Outputs re-evaluate from the cleared state.
- An E slot that is invalid never flushes and never updates the BHT, regardless of iBranchE/iJumpE.

## Configuration
Macro BP_PERF_CNT_EN.
- Defined: oBranchCnt increments when the E slot is valid and (iBranchE|iJumpE); oMispredCnt increments on each mispredict. Both counters wrap at 2^32.
- Undefined: neither counter register exists and both outputs are tied to 32'd0.

## Structure
Package bp_pkg holds:
- opcode constants OP_BRANCH=7'd99 and OP_JAL=7'd111;
- counter encodings SNT=00, WNT=01, WT=10, ST=11;
- the slot typedef struct.

Sub-module bp_bht:
- counter array, one combinational read port and one synchronous write port with saturating update;
- reset to WNT;
- parameterised by IDX_BITS.

## Test plan
1. Reset, then PC=0x100 with a BEQ of offset -16 (first encounter): prediction not taken, oPCNextF=0x104. The branch resolves taken in E: oFlushFD=1, oPCNextF=0xF0, and BHT[idx] goes 01->10.
2. Same BEQ taken a second time: predicted taken, oPCNextF=0xF0 in F, no flush in E, and the counter goes 10->11. Then a not-taken resolution: flush, oPCNextF=0x104, counter 11->10.
3. JAL at 0x200 with offset +0x40: oPCNextF=0x240 in F, no flush. JALR at 0x300 resolving to 0x80: flush with oPCNextF=0x80.
4. iStallF=1 for 2 cycles while a predicted-taken branch sits in D: the D slot holds and E receives bubbles (no flush, no BHT update). After release the branch resolves normally.
5. Collision: an E update to index 5 in the same cycle as an F read of index 5 returns the old counter. The read in the following cycle sees the new value.
6. With BP_PERF_CNT_EN defined: 10 branches with 3 mispredicts give oBranchCnt=10 and oMispredCnt=3. Without the macro both read 0. Asserting iRstN low mid-sequence clears both slots and the counters.
